array_sweep_bank: RTL and testbench

Parametrised two-view array store for waveform and debugger regression vectors. It holds DEPTH elements of WIDTH bits in two views: a packed vector (a) and an unpacked memory (b).
- A self-timed sweep FSM fills both views over NUM_PASS passes with a deterministic pattern, one element per clock.
- A manual write port and a registered read port are also provided.
- It sits under a top-level vector harness and gives the waveform dump structured, multi-dimensional signals that change over time.

---
 rtl/array_sweep_pkg.sv | 37 +++
 rtl/array_sweep_ctrl.sv | 98 +++++++++
 rtl/array_sweep_bank.sv | 105 ++++++++++
 tb/tb_array_sweep_bank.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_sweep_pkg.sv
// Shared types and helpers for the array sweep bank: FSM states, the 32-bit
// working type and the deterministic sweep pattern.
package array_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef logic [31:0] elem_t;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int idx_w_of(input int depth);
      return cnt_w(depth);
   endfunction

   function automatic int pass_w_of(input int num_pass);
      return cnt_w(num_pass + 1);
   endfunction

   // Pattern value at 32 bits, reduced modulo 2^width.
   function automatic elem_t sweep_val(input elem_t idx, input elem_t pass,
                                       input elem_t offset, input elem_t stride,
                                       input int width);
      elem_t raw;
      raw = idx + offset + pass * stride;
      if (width < 32) raw = raw & ((elem_t'(1) << width) - elem_t'(1));
      return raw;
   endfunction

endpackage

// File: rtl/array_sweep_ctrl.sv
// Sweep sequencer: walks elem/pass/hold counters and tells the parent which
// element to fill on each FILL cycle.
module array_sweep_ctrl
   import array_sweep_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int NUM_PASS    = 2,
   parameter int HOLD_CYCLES = 1,
   parameter int IDX_W       = idx_w_of(DEPTH),
   parameter int PASS_W      = pass_w_of(NUM_PASS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              idle,
   output logic              busy,
   output logic              done,
   output logic [PASS_W-1:0] pass_cnt,
   output logic              fill_we,
   output logic [IDX_W-1:0]  fill_idx
);

   localparam int HOLD_W = cnt_w(HOLD_CYCLES);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    elem_q, elem_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      pass_d  = pass_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               elem_d  = '0;
               pass_d  = '0;
            end
         end
         FILL: begin
            if (elem_q == IDX_W'(DEPTH - 1)) begin
               state_d = HOLD;
               hold_d  = HOLD_W'(HOLD_CYCLES - 1);
            end else begin
               elem_d = elem_q + 1'b1;
            end
         end
         HOLD: begin
            if (hold_q == '0) begin
               if (pass_q == PASS_W'(NUM_PASS - 1)) begin
                  state_d = DONE;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  elem_d  = '0;
                  state_d = FILL;
               end
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Status flags follow the next state so they line up with it.
      busy_d = (state_d == FILL) || (state_d == HOLD);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         elem_q  <= '0;
         pass_q  <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         pass_q  <= pass_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign idle     = (state_q == IDLE);
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass_cnt = pass_q;
   assign fill_we  = (state_q == FILL);
   assign fill_idx = elem_q;

endmodule

// File: rtl/array_sweep_bank.sv
// Two-view element store (packed a_flat, unpacked b) filled by a timed sweep
// or by a manual write port while idle, with a registered read port.
module array_sweep_bank
   import array_sweep_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int NUM_PASS    = 2,
   parameter int STRIDE      = 10,
   parameter int A_OFFSET    = 1,
   parameter int B_OFFSET    = 2,
   parameter int HOLD_CYCLES = 1,
   localparam int IDX_W      = idx_w_of(DEPTH),
   localparam int PASS_W     = pass_w_of(NUM_PASS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [WIDTH-1:0]       wr_data_a,
   input  logic [WIDTH-1:0]       wr_data_b,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [WIDTH-1:0]       rd_data_a,
   output logic [WIDTH-1:0]       rd_data_b,
   output logic [DEPTH*WIDTH-1:0] a_flat,
   output logic                   busy,
   output logic                   done,
   output logic [PASS_W-1:0]      pass_cnt
);

   logic             idle;
   logic             fill_we;
   logic [IDX_W-1:0] fill_idx;
   logic             man_we;

   array_sweep_ctrl #(
      .DEPTH       (DEPTH),
      .NUM_PASS    (NUM_PASS),
      .HOLD_CYCLES (HOLD_CYCLES),
      .IDX_W       (IDX_W),
      .PASS_W      (PASS_W)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .idle     (idle),
      .busy     (busy),
      .done     (done),
      .pass_cnt (pass_cnt),
      .fill_we  (fill_we),
      .fill_idx (fill_idx)
   );

   // start wins over a simultaneous manual write.
   assign man_we = idle && wr_en && !start;

   logic [DEPTH*WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0]       b_q [DEPTH];
   logic [WIDTH-1:0]       b_d [DEPTH];
   logic [WIDTH-1:0]       rd_data_a_q, rd_data_a_d;
   logic [WIDTH-1:0]       rd_data_b_q, rd_data_b_d;

   // Indices with no matching element (>= DEPTH) write nothing and read 0.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fill_we && (fill_idx == IDX_W'(i))) begin
            a_d[i*WIDTH +: WIDTH] = WIDTH'(sweep_val(elem_t'(i), elem_t'(pass_cnt),
                                       elem_t'(A_OFFSET), elem_t'(STRIDE), WIDTH));
            b_d[i]                = WIDTH'(sweep_val(elem_t'(i), elem_t'(pass_cnt),
                                       elem_t'(B_OFFSET), elem_t'(STRIDE), WIDTH));
         end else if (man_we && (wr_idx == IDX_W'(i))) begin
            a_d[i*WIDTH +: WIDTH] = wr_data_a;
            b_d[i]                = wr_data_b;
         end
         if (rd_idx == IDX_W'(i)) begin
            rd_data_a_d = a_q[i*WIDTH +: WIDTH];
            rd_data_b_d = b_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         for (int i = 0; i < DEPTH; i++) b_q[i] <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
      end
   end

   assign a_flat    = a_q;
   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_array_sweep_bank.sv
// Directed bench for array_sweep_bank: default, narrow/odd-depth and long-hold
// instances driven with hand-computed vectors and sweep sequences.
module tb_array_sweep_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Default instance
   logic        s1, we1, busy1, done1;
   logic [1:0]  wi1, ri1, pc1;
   logic [15:0] wa1, wb1, ra1, rb1;
   logic [63:0] af1;

   // WIDTH=4, DEPTH=3, STRIDE=7, NUM_PASS=3
   logic        s2, we2, busy2, done2;
   logic [1:0]  wi2, ri2, pc2;
   logic [3:0]  wa2, wb2, ra2, rb2;
   logic [11:0] af2;

   // HOLD_CYCLES=3
   logic        s3, we3, busy3, done3;
   logic [1:0]  wi3, ri3, pc3;
   logic [15:0] wa3, wb3, ra3, rb3;
   logic [63:0] af3;

   array_sweep_bank dut1 (
      .clk(clk), .rst(rst), .start(s1), .wr_en(we1), .wr_idx(wi1),
      .wr_data_a(wa1), .wr_data_b(wb1), .rd_idx(ri1), .rd_data_a(ra1),
      .rd_data_b(rb1), .a_flat(af1), .busy(busy1), .done(done1), .pass_cnt(pc1)
   );

   array_sweep_bank #(.WIDTH(4), .DEPTH(3), .STRIDE(7), .NUM_PASS(3)) dut2 (
      .clk(clk), .rst(rst), .start(s2), .wr_en(we2), .wr_idx(wi2),
      .wr_data_a(wa2), .wr_data_b(wb2), .rd_idx(ri2), .rd_data_a(ra2),
      .rd_data_b(rb2), .a_flat(af2), .busy(busy2), .done(done2), .pass_cnt(pc2)
   );

   array_sweep_bank #(.HOLD_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(s3), .wr_en(we3), .wr_idx(wi3),
      .wr_data_a(wa3), .wr_data_b(wb3), .rd_idx(ri3), .rd_data_a(ra3),
      .rd_data_b(rb3), .a_flat(af3), .busy(busy3), .done(done3), .pass_cnt(pc3)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        wr_en;
      logic [1:0]  wr_idx;
      logic [15:0] wa;
      logic [15:0] wb;
      logic [1:0]  rd_idx;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs [7];

   // Full default sweep; exp_e1 is a_flat expected right after the first fill edge.
   task automatic sweep1(input string tag, input logic [63:0] exp_e1);
      s1 = 1'b1; we1 = 1'b1; wi1 = 2'd1; wa1 = 16'hDEAD; wb1 = 16'hDEAD;
      tick;                                   // edge 0
      chk({tag, " busy_e0"}, 64'(busy1), 64'd1);
      s1 = 1'b0; wi1 = 2'd0; wa1 = 16'hFFFF; wb1 = 16'hFFFF;
      tick;                                   // edge 1
      chk({tag, " a_e1"}, af1, exp_e1);
      repeat (3) tick;                        // edges 2-4
      chk({tag, " a_pass0"}, af1, {16'd4, 16'd3, 16'd2, 16'd1});
      for (int k = 0; k < 4; k++) begin       // edges 5-8, reads see pre-write b
         ri1 = 2'(k);
         tick;
         chk($sformatf("%s b_pass0[%0d]", tag, k), 64'(rb1), 64'(2 + k));
      end
      tick;                                   // edge 9
      chk({tag, " a_pass1"}, af1, {16'd14, 16'd13, 16'd12, 16'd11});
      chk({tag, " pc_e9"}, 64'(pc1), 64'd1);
      tick;                                   // edge 10
      chk({tag, " done_e10"}, 64'(done1), 64'd1);
      chk({tag, " busy_e10"}, 64'(busy1), 64'd0);
      tick;                                   // edge 11
      chk({tag, " done_e11"}, 64'(done1), 64'd0);
      chk({tag, " busy_e11"}, 64'(busy1), 64'd0);
      chk({tag, " pc_e11"}, 64'(pc1), 64'd1);
      we1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ri1 = 2'(k);
         tick;
         chk($sformatf("%s rd_a[%0d]", tag, k), 64'(ra1), 64'(11 + k));
         chk($sformatf("%s rd_b[%0d]", tag, k), 64'(rb1), 64'(12 + k));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 16'h1234, 2'd2, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 16'hBEEF, 16'h1234};
      vecs[2] = '{1'b1, 2'd0, 16'h0001, 16'hFFFF, 2'd1, 16'h0000, 16'h0000};
      vecs[3] = '{1'b1, 2'd3, 16'hA5A5, 16'h5A5A, 2'd0, 16'h0001, 16'hFFFF};
      vecs[4] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd3, 16'hA5A5, 16'h5A5A};
      vecs[5] = '{1'b1, 2'd2, 16'hCAFE, 16'h0BAD, 2'd2, 16'hBEEF, 16'h1234};
      vecs[6] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 16'hCAFE, 16'h0BAD};

      rst = 1'b1;
      s1 = 0; we1 = 0; wi1 = 0; ri1 = 0; wa1 = 0; wb1 = 0;
      s2 = 0; we2 = 0; wi2 = 0; ri2 = 0; wa2 = 0; wb2 = 0;
      s3 = 0; we3 = 0; wi3 = 0; ri3 = 0; wa3 = 0; wb3 = 0;
      #12;
      chk("rst a_flat1", af1, 64'd0);
      chk("rst busy1", 64'(busy1), 64'd0);
      chk("rst done1", 64'(done1), 64'd0);
      chk("rst pc1", 64'(pc1), 64'd0);
      chk("rst rd1", {32'd0, ra1, rb1}, 64'd0);
      chk("rst a_flat2", 64'(af2), 64'd0);
      chk("rst a_flat3", af3, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Manual write/read vectors on the default instance
      for (int i = 0; i < 7; i++) begin
         we1 = vecs[i].wr_en; wi1 = vecs[i].wr_idx;
         wa1 = vecs[i].wa;    wb1 = vecs[i].wb;
         ri1 = vecs[i].rd_idx;
         tick;
         chk($sformatf("vec%0d rd_a", i), 64'(ra1), 64'(vecs[i].ea));
         chk($sformatf("vec%0d rd_b", i), 64'(rb1), 64'(vecs[i].eb));
      end
      we1 = 1'b0;
      chk("manual a_flat", af1, {16'hA5A5, 16'hCAFE, 16'h0000, 16'h0001});

      sweep1("sweep", {16'hA5A5, 16'hCAFE, 16'h0000, 16'h0001});

      // Reset in the middle of a sweep
      s1 = 1'b1;
      tick;
      s1 = 1'b0;
      repeat (6) tick;
      chk("mid pc_e6", 64'(pc1), 64'd1);
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk("mid rst a_flat", af1, 64'd0);
      chk("mid rst busy", 64'(busy1), 64'd0);
      chk("mid rst pc", 64'(pc1), 64'd0);
      chk("mid rst done", 64'(done1), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      sweep1("repeat", {16'd0, 16'd0, 16'd0, 16'd1});

      // Narrow, odd-depth, three-pass instance
      s2 = 1'b1;
      tick;                                   // edge 0
      s2 = 1'b0;
      repeat (3) tick;                        // edge 3
      chk("w4 a_pass0", 64'(af2), 64'h321);
      repeat (4) tick;                        // edge 7
      chk("w4 a_pass1", 64'(af2), 64'hA98);
      chk("w4 pc_e7", 64'(pc2), 64'd1);
      repeat (4) tick;                        // edge 11
      chk("w4 a_pass2", 64'(af2), 64'h10F);
      chk("w4 pc_e11", 64'(pc2), 64'd2);
      chk("w4 done_e11", 64'(done2), 64'd0);
      tick;                                   // edge 12
      chk("w4 done_e12", 64'(done2), 64'd1);
      chk("w4 busy_e12", 64'(busy2), 64'd0);
      tick;
      chk("w4 done_e13", 64'(done2), 64'd0);
      ri2 = 2'd2;
      tick;
      chk("w4 rd_a2", 64'(ra2), 64'd1);
      chk("w4 rd_b2", 64'(rb2), 64'd2);
      we2 = 1'b1; wi2 = 2'd3; wa2 = 4'hF; wb2 = 4'hF; ri2 = 2'd3;
      tick;
      we2 = 1'b0;
      chk("w4 rd_oob_a", 64'(ra2), 64'd0);
      chk("w4 rd_oob_b", 64'(rb2), 64'd0);
      chk("w4 wr_oob a_flat", 64'(af2), 64'h10F);
      ri2 = 2'd0;
      tick;
      chk("w4 rd_b0", 64'(rb2), 64'd0);

      // Three hold cycles between passes
      s3 = 1'b1;
      tick;                                   // edge 0
      s3 = 1'b0;
      repeat (4) tick;                        // edge 4
      chk("h3 a_pass0", af3, {16'd4, 16'd3, 16'd2, 16'd1});
      for (int k = 5; k <= 6; k++) begin
         tick;
         chk($sformatf("h3 a_e%0d", k), af3, {16'd4, 16'd3, 16'd2, 16'd1});
         chk($sformatf("h3 pc_e%0d", k), 64'(pc3), 64'd0);
         chk($sformatf("h3 busy_e%0d", k), 64'(busy3), 64'd1);
      end
      tick;                                   // edge 7
      chk("h3 pc_e7", 64'(pc3), 64'd1);
      chk("h3 a_e7", af3, {16'd4, 16'd3, 16'd2, 16'd1});
      tick;                                   // edge 8
      chk("h3 a_e8", af3, {16'd4, 16'd3, 16'd2, 16'd11});
      repeat (5) tick;                        // edge 13
      chk("h3 done_e13", 64'(done3), 64'd0);
      tick;                                   // edge 14
      chk("h3 done_e14", 64'(done3), 64'd1);
      chk("h3 a_final", af3, {16'd14, 16'd13, 16'd12, 16'd11});
      tick;
      chk("h3 done_e15", 64'(done3), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
